// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one single-ported, variable-latency memory between the fetch and data ports
module memory_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              mem_stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic              ram_byte_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          owner_mem;
    logic          abort_pend;
    logic [SW-1:0] streak;
    logic          grant_if;

    // Data port has priority unless it has starved a waiting fetch for the full streak
    assign grant_if  = if_req & (~mem_req | (streak == STREAK_MAX));
    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = mem_req & ~mem_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_mem   <= 1'b0;
            abort_pend  <= 1'b0;
            streak      <= '0;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_byte_en <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            if_rdata    <= '0;
            if_valid    <= 1'b0;
            mem_rdata   <= '0;
            mem_valid   <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || mem_req) begin
                        ram_req   <= 1'b1;
                        state     <= ACCESS;
                        owner_mem <= ~grant_if;
                        if (grant_if) begin
                            ram_addr    <= if_addr;
                            ram_wdata   <= '0;
                            ram_we      <= 1'b0;
                            ram_byte_en <= 1'b0;
                            streak      <= '0;
                            abort_pend  <= if_abort;
                        end else begin
                            ram_addr    <= mem_addr;
                            ram_wdata   <= mem_wdata;
                            ram_we      <= mem_we;
                            ram_byte_en <= mem_byte_en;
                            if (!if_req)
                                streak <= '0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + SW'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        ram_req    <= 1'b0;
                        state      <= RESP;
                        abort_pend <= 1'b0;
                        if (owner_mem) begin
                            mem_valid <= 1'b1;
                            if (!ram_we)
                                mem_rdata <= ram_rdata;
                        end else if (!abort_pend && !if_abort) begin
                            if_rdata <= ram_rdata;
                            if_valid <= 1'b1;
                        end
                    end else if (!owner_mem && if_abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_abort;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid, if_stall;
    logic        mem_req, mem_we, mem_byte_en;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, mem_stall;
    logic        ram_req, ram_we, ram_byte_en, ram_ready;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int ram_wait = 0;
    int wcnt = 0;

    always #5 clock = ~clock;

    // RAM model: ready after ram_wait wait cycles, data = addr ^ 16'h1224
    always @(posedge clock) begin
        if (!ram_req || ram_ready) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end
    assign ram_ready = ram_req && (wcnt == ram_wait);
    assign ram_rdata = ram_addr ^ 16'h1224;

    memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_DATA_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_byte_en(ram_byte_en),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic wait_if_valid(input string tag, input int max);
        int n = 0;
        while (!if_valid && n < max) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, if_valid}, 32'd1);
    endtask

    task automatic wait_mem_valid(input string tag, input int max);
        int n = 0;
        while (!mem_valid && n < max) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, mem_valid}, 32'd1);
    endtask

    initial begin
        logic [15:0] grants [10];
        logic [15:0] exp_g  [10];
        int          ng;
        logic        prev_req;
        logic        saw_valid;

        exp_g = '{16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0010,
                  16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0010};

        reset = 1'b0;
        if_req = 0; if_abort = 0; if_addr = 16'h0000;
        mem_req = 0; mem_we = 0; mem_byte_en = 0; mem_addr = 16'h0000; mem_wdata = 16'h0000;

        // 1: reset values, then reset mid-ACCESS
        tick();
        check_eq("rst_ram_req",   {31'd0, ram_req}, 32'd0);
        check_eq("rst_if_valid",  {31'd0, if_valid}, 32'd0);
        check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_ram_addr",  {16'd0, ram_addr}, 32'd0);
        check_eq("rst_if_rdata",  {16'd0, if_rdata}, 32'd0);
        check_eq("rst_mem_rdata", {16'd0, mem_rdata}, 32'd0);
        reset = 1'b1;
        tick();
        ram_wait = 5;
        if_addr = 16'h0000;
        if_req = 1;
        tick();
        check_eq("t1_issue", {31'd0, ram_req}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check_eq("t1_abandon_req",  {31'd0, ram_req}, 32'd0);
        check_eq("t1_abandon_ifv",  {31'd0, if_valid}, 32'd0);
        check_eq("t1_abandon_memv", {31'd0, mem_valid}, 32'd0);
        tick();
        reset = 1'b1;
        ram_wait = 1;
        tick();
        check_eq("t1_reissue", {31'd0, ram_req}, 32'd1);
        wait_if_valid("t1_valid", 10);
        check_eq("t1_rdata", {16'd0, if_rdata}, 32'h1224);
        if_req = 0;
        tick();

        // 2: fetch only, one RAM wait cycle
        ram_wait = 1;
        if_addr = 16'h0010;
        if_req = 1;
        #1 check_eq("t2_stall_c0", {31'd0, if_stall}, 32'd1);
        tick();
        check_eq("t2_stall_c1", {31'd0, if_stall}, 32'd1);
        check_eq("t2_ramreq_c1", {31'd0, ram_req}, 32'd1);
        check_eq("t2_ramaddr", {16'd0, ram_addr}, 32'h0010);
        tick();
        check_eq("t2_stall_c2", {31'd0, if_stall}, 32'd1);
        check_eq("t2_novalid_c2", {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("t2_valid_c3", {31'd0, if_valid}, 32'd1);
        check_eq("t2_stall_c3", {31'd0, if_stall}, 32'd0);
        check_eq("t2_rdata", {16'd0, if_rdata}, 32'h1234);
        if_req = 0;
        tick();
        check_eq("t2_pulse_end", {31'd0, if_valid}, 32'd0);

        // 3: simultaneous requests, data first
        ram_wait = 0;
        mem_addr = 16'h0040; mem_we = 0; mem_req = 1;
        if_addr = 16'h0010; if_req = 1;
        tick();
        check_eq("t3_mem_first", {16'd0, ram_addr}, 32'h0040);
        check_eq("t3_if_stall_c1", {31'd0, if_stall}, 32'd1);
        tick();
        check_eq("t3_mem_valid", {31'd0, mem_valid}, 32'd1);
        check_eq("t3_mem_rdata", {16'd0, mem_rdata}, 32'h1264);
        check_eq("t3_if_stall_c2", {31'd0, if_stall}, 32'd1);
        mem_req = 0;
        tick();
        check_eq("t3_idle_c3", {31'd0, ram_req}, 32'd0);
        tick();
        check_eq("t3_fetch_issue", {31'd0, ram_req}, 32'd1);
        check_eq("t3_fetch_addr", {16'd0, ram_addr}, 32'h0010);
        wait_if_valid("t3_if_valid", 10);
        if_req = 0;
        tick();

        // 4: starvation limit
        ram_wait = 0;
        mem_addr = 16'h0080; mem_we = 0; mem_req = 1;
        if_addr = 16'h0010; if_req = 1;
        ng = 0;
        prev_req = 1'b0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            tick();
            if (ram_req && !prev_req) begin
                grants[ng] = ram_addr;
                ng++;
            end
            prev_req = ram_req;
        end
        check_eq("t4_grant_count", ng, 10);
        for (int i = 0; i < ng; i++)
            check_eq($sformatf("t4_grant%0d", i), {16'd0, grants[i]}, {16'd0, exp_g[i]});
        check_eq("t4_mem_stall_during_fetch", {31'd0, mem_stall}, 32'd1);
        wait_if_valid("t4_if_valid", 10);
        if_req = 0;
        wait_mem_valid("t4_mem_valid", 10);
        mem_req = 0;
        tick();

        // 5: abort during fetch ACCESS, then abort coinciding with ram_ready
        ram_wait = 2;
        if_addr = 16'h0030;
        if_req = 1;
        tick();
        check_eq("t5_issue", {31'd0, ram_req}, 32'd1);
        if_abort = 1;
        tick();
        if_abort = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_valid |= if_valid;
        end
        check_eq("t5_no_valid", {31'd0, saw_valid}, 32'd0);
        check_eq("t5_rdata_held", {16'd0, if_rdata}, 32'h1234);
        wait_if_valid("t5_refetch_valid", 20);
        check_eq("t5_refetch_rdata", {16'd0, if_rdata}, 32'h1214);
        if_req = 0;
        tick();
        ram_wait = 0;
        if_addr = 16'h0050;
        if_req = 1;
        tick();
        if_abort = 1;
        tick();
        if_abort = 0;
        check_eq("t5_ready_abort_novalid", {31'd0, if_valid}, 32'd0);
        check_eq("t5_ready_abort_held", {16'd0, if_rdata}, 32'h1214);
        wait_if_valid("t5b_refetch_valid", 20);
        check_eq("t5b_refetch_rdata", {16'd0, if_rdata}, 32'h1274);
        if_req = 0;
        tick();

        // 6: byte write
        ram_wait = 1;
        mem_we = 1; mem_byte_en = 1; mem_addr = 16'h0021; mem_wdata = 16'h00AB;
        mem_req = 1;
        tick();
        check_eq("t6_ram_req", {31'd0, ram_req}, 32'd1);
        check_eq("t6_ram_we", {31'd0, ram_we}, 32'd1);
        check_eq("t6_ram_be", {31'd0, ram_byte_en}, 32'd1);
        check_eq("t6_ram_addr", {16'd0, ram_addr}, 32'h0021);
        check_eq("t6_ram_wdata", {16'd0, ram_wdata}, 32'h00AB);
        tick();
        check_eq("t6_mem_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        check_eq("t6_mem_valid", {31'd0, mem_valid}, 32'd1);
        check_eq("t6_mem_stall_low", {31'd0, mem_stall}, 32'd0);
        check_eq("t6_mem_rdata_held", {16'd0, mem_rdata}, 32'h12A4);
        mem_req = 0; mem_we = 0; mem_byte_en = 0;
        tick();
        check_eq("t6_pulse_end", {31'd0, mem_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
